// File: rtl/looper_fetch_pkg.sv
// Shared definitions for the fetch packing path.
//   AW_DEF       default address / instruction width
//   NOP_INST     encoding substituted into nulled immediate-jump slots
//   JMP_OPC      immediate-jump opcode nibble used by the fetch predecoder
//   fetch_slot_t one packed slot: {pc, inst, recv_pc, pred}
package looper_fetch_pkg;

  localparam int unsigned     AW_DEF   = 16;
  localparam logic [AW_DEF-1:0] NOP_INST = 16'h0000;
  localparam logic [3:0]      JMP_OPC  = 4'b1111;

  typedef struct packed {
    logic [AW_DEF-1:0] pc;
    logic [AW_DEF-1:0] inst;
    logic [AW_DEF-1:0] recv_pc;
    logic              pred;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_pack.sv
// Combinational packer for one fetch group.
//   pc_i          PC of slot 0
//   inst_i        WIDTH instructions, slot 0 in the MSBs
//   br_sel_i      conditional-branch slot mask, bit WIDTH-1 is slot 0
//   br_tgt_i      MAX_BR branch targets, branch 0 in the MSBs
//   pred_taken_i  MAX_BR predictions, branch 0 is the MSB
//   imm_jmp_i     immediate-jump slot mask, bit WIDTH-1 is slot 0
//   pc_o / inst_o / recv_o / pred_o  packed per-slot results, slot 0 in the MSBs
//   overflow_o    group carries more than MAX_BR branches
module fetch_slot_pack
  import looper_fetch_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MAX_BR = 2,
  parameter int unsigned AW     = AW_DEF
) (
  input  logic [AW-1:0]        pc_i,
  input  logic [WIDTH*AW-1:0]  inst_i,
  input  logic [WIDTH-1:0]     br_sel_i,
  input  logic [MAX_BR*AW-1:0] br_tgt_i,
  input  logic [MAX_BR-1:0]    pred_taken_i,
  input  logic [WIDTH-1:0]     imm_jmp_i,
  output logic [WIDTH*AW-1:0]  pc_o,
  output logic [WIDTH*AW-1:0]  inst_o,
  output logic [WIDTH*AW-1:0]  recv_o,
  output logic [WIDTH-1:0]     pred_o,
  output logic                 overflow_o
);

  logic [AW-1:0] slot_pc;
  logic [AW-1:0] sel_tgt;
  logic          sel_pred;
  int unsigned   n_br;

  always_comb begin
    pc_o       = '0;
    inst_o     = '0;
    recv_o     = '0;
    pred_o     = '0;
    slot_pc    = '0;
    sel_tgt    = '0;
    sel_pred   = 1'b0;
    n_br       = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      slot_pc = pc_i + AW'(i);
      pc_o[(WIDTH-1-i)*AW +: AW]   = slot_pc;
      inst_o[(WIDTH-1-i)*AW +: AW] = imm_jmp_i[WIDTH-1-i] ? AW'(NOP_INST)
                                                          : inst_i[(WIDTH-1-i)*AW +: AW];
      if (br_sel_i[WIDTH-1-i]) begin
        // Branch ordinal selects prediction/target with a constant-index scan.
        sel_tgt  = '0;
        sel_pred = 1'b0;
        for (int unsigned k = 0; k < MAX_BR; k++) begin
          if (k == n_br) begin
            sel_pred = pred_taken_i[MAX_BR-1-k];
            sel_tgt  = br_tgt_i[(MAX_BR-1-k)*AW +: AW];
          end
        end
        // A jump on the same slot still consumes an ordinal but suppresses the branch.
        if (n_br < MAX_BR && !imm_jmp_i[WIDTH-1-i]) begin
          pred_o[WIDTH-1-i]            = sel_pred;
          recv_o[(WIDTH-1-i)*AW +: AW] = sel_pred ? slot_pc + AW'(1) : sel_tgt;
        end
        n_br = n_br + 1;
      end
    end
    overflow_o = (n_br > MAX_BR);
  end

endmodule

// File: rtl/fetch_pack_queue.sv
// Fetch-group packer followed by a DEPTH-entry FIFO feeding decode.
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 synchronous clear; drops a same-cycle push, ignores pop
//   in_valid / in_ready   input handshake; in_ready = queue not full
//   in_pc .. in_imm_jmp   raw fetch group (see fetch_slot_pack)
//   out_valid / out_ready output handshake for the head entry
//   out_pc .. out_pred    head entry, all zero while empty
//   count                 occupancy
//   br_overflow           sticky: a pushed group held more than MAX_BR branches
module fetch_pack_queue
  import looper_fetch_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MAX_BR = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [AW-1:0]               in_pc,
  input  logic [WIDTH*AW-1:0]         in_inst,
  input  logic [WIDTH-1:0]            in_br_sel,
  input  logic [MAX_BR*AW-1:0]        in_br_tgt,
  input  logic [MAX_BR-1:0]           in_pred_taken,
  input  logic [WIDTH-1:0]            in_imm_jmp,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH*AW-1:0]         out_pc,
  output logic [WIDTH*AW-1:0]         out_inst,
  output logic [WIDTH*AW-1:0]         out_recv_pc,
  output logic [WIDTH-1:0]            out_pred,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        br_overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned GW = WIDTH*AW;
  localparam int unsigned EW = 3*GW + WIDTH;

  logic [GW-1:0]    pk_pc, pk_inst, pk_recv;
  logic [WIDTH-1:0] pk_pred;
  logic             pk_ovf;

  fetch_slot_pack #(
    .WIDTH  (WIDTH),
    .MAX_BR (MAX_BR),
    .AW     (AW)
  ) u_pack (
    .pc_i         (in_pc),
    .inst_i       (in_inst),
    .br_sel_i     (in_br_sel),
    .br_tgt_i     (in_br_tgt),
    .pred_taken_i (in_pred_taken),
    .imm_jmp_i    (in_imm_jmp),
    .pc_o         (pk_pc),
    .inst_o       (pk_inst),
    .recv_o       (pk_recv),
    .pred_o       (pk_pred),
    .overflow_o   (pk_ovf)
  );

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;
  logic [EW-1:0] head;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        ovf_d    = ovf_q | pk_ovf;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: an empty queue masks the head to zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {pk_pc, pk_inst, pk_recv, pk_pred};
    end
  end

  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc      = head[EW-1 -: GW];
  assign out_inst    = head[EW-GW-1 -: GW];
  assign out_recv_pc = head[WIDTH +: GW];
  assign out_pred    = head[WIDTH-1:0];
  assign count       = count_q;
  assign br_overflow = ovf_q;

endmodule

// File: tb/tb_fetch_pack_queue.sv
module tb_fetch_pack_queue;
  import looper_fetch_pkg::*;

  typedef fetch_slot_t [0:3] grp_t;

  typedef struct {
    logic [15:0] pc;
    logic [63:0] inst;
    logic [3:0]  br;
    logic [31:0] tgt;
    logic [1:0]  pr;
    logic [3:0]  jmp;
    logic [63:0] e_pc;
    logic [63:0] e_inst;
    logic [63:0] e_recv;
    logic [3:0]  e_pred;
    logic        e_ovf;
  } vec_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, br_overflow;
  logic [15:0] in_pc;
  logic [63:0] in_inst, out_pc, out_inst, out_recv_pc;
  logic [3:0]  in_br_sel, in_imm_jmp, out_pred;
  logic [31:0] in_br_tgt;
  logic [1:0]  in_pred_taken;
  logic [2:0]  count;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  grp_t        mq[$];
  logic        movf = 1'b0;
  vec_t        vt[5];

  fetch_pack_queue #(.WIDTH(4), .MAX_BR(2), .DEPTH(4), .AW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_br_sel(in_br_sel), .in_br_tgt(in_br_tgt), .in_pred_taken(in_pred_taken),
    .in_imm_jmp(in_imm_jmp), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_recv_pc(out_recv_pc),
    .out_pred(out_pred), .count(count), .br_overflow(br_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference packing from the slot rules: list the branch slots, honour the first two.
  function automatic grp_t model_pack(input logic [15:0] pc, input logic [63:0] inst,
                                      input logic [3:0] br, input logic [31:0] tgt,
                                      input logic [1:0] pr, input logic [3:0] jmp);
    grp_t g;
    int   slots[$];
    int   s;
    logic taken;
    for (int i = 0; i < 4; i++) begin
      g[i].pc      = pc + 16'(i);
      g[i].inst    = jmp[3-i] ? NOP_INST : inst[(3-i)*16 +: 16];
      g[i].recv_pc = '0;
      g[i].pred    = 1'b0;
      if (br[3-i]) slots.push_back(i);
    end
    for (int k = 0; k < slots.size() && k < 2; k++) begin
      s = slots[k];
      if (!jmp[3-s]) begin
        taken        = pr[1-k];
        g[s].pred    = taken;
        g[s].recv_pc = taken ? g[s].pc + 16'd1 : tgt[(1-k)*16 +: 16];
      end
    end
    return g;
  endfunction

  task automatic check_all();
    grp_t        h;
    logic [63:0] epc, einst, erecv;
    logic [3:0]  epred;
    epc = '0; einst = '0; erecv = '0; epred = '0;
    if (mq.size() != 0) begin
      h = mq[0];
      for (int s = 0; s < 4; s++) begin
        epc[(3-s)*16 +: 16]   = h[s].pc;
        einst[(3-s)*16 +: 16] = h[s].inst;
        erecv[(3-s)*16 +: 16] = h[s].recv_pc;
        epred[3-s]            = h[s].pred;
      end
    end
    chk("out_valid", out_valid, mq.size() != 0);
    chk("count", count, mq.size());
    chk("in_ready", in_ready, mq.size() != 4);
    chk("br_overflow", br_overflow, movf);
    chk("out_pc", out_pc, epc);
    chk("out_inst", out_inst, einst);
    chk("out_recv_pc", out_recv_pc, erecv);
    chk("out_pred", out_pred, epred);
  endtask

  // Inputs are driven at the negedge before this is called.
  task automatic cycle();
    logic push, pop, bigbr;
    grp_t g;
    push  = in_valid && (mq.size() != 4);
    pop   = (mq.size() != 0) && out_ready;
    bigbr = ($countones(in_br_sel) > 2);
    g     = model_pack(in_pc, in_inst, in_br_sel, in_br_tgt, in_pred_taken, in_imm_jmp);
    @(posedge clk);
    if (flush) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(g);
        if (bigbr) movf = 1'b1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic [15:0] pc, input logic [63:0] inst, input logic [3:0] br,
                       input logic [31:0] tgt, input logic [1:0] pr, input logic [3:0] jmp,
                       input logic v);
    in_pc = pc; in_inst = inst; in_br_sel = br; in_br_tgt = tgt;
    in_pred_taken = pr; in_imm_jmp = jmp; in_valid = v;
  endtask

  task automatic drive_rand(input logic v);
    drive(16'($urandom), {$urandom, $urandom}, 4'($urandom), $urandom,
          2'($urandom), 4'($urandom), v);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive('0, '0, '0, '0, '0, '0, 1'b0);

    vt[0] = '{16'h0100, 64'h1111_2222_3333_4444, 4'b0000, 32'h0200_0300, 2'b00, 4'b0000,
              64'h0100_0101_0102_0103, 64'h1111_2222_3333_4444, 64'h0, 4'b0000, 1'b0};
    vt[1] = '{16'h0100, 64'h1111_2222_3333_4444, 4'b1001, 32'h0200_0300, 2'b10, 4'b0000,
              64'h0100_0101_0102_0103, 64'h1111_2222_3333_4444,
              64'h0101_0000_0000_0300, 4'b1000, 1'b0};
    vt[2] = '{16'h0100, 64'h1111_2222_3333_4444, 4'b1110, 32'h0A00_0B00, 2'b00, 4'b0001,
              64'h0100_0101_0102_0103, 64'h1111_2222_3333_0000,
              64'h0A00_0B00_0000_0000, 4'b0000, 1'b1};
    vt[3] = '{16'hFFFE, 64'h1111_2222_3333_4444, 4'b0010, 32'h0500_0600, 2'b10, 4'b0000,
              64'hFFFE_FFFF_0000_0001, 64'h1111_2222_3333_4444,
              64'h0000_0000_0001_0000, 4'b0010, 1'b0};
    vt[4] = '{16'h0100, 64'h1111_2222_3333_4444, 4'b1100, 32'h0700_0800, 2'b11, 4'b1000,
              64'h0100_0101_0102_0103, 64'h0000_2222_3333_4444,
              64'h0000_0102_0000_0000, 4'b0100, 1'b0};

    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);
    check_all();

    // Directed packing vectors, each into an emptied queue.
    for (int i = 0; i < 5; i++) begin
      flush = 1'b1; in_valid = 1'b0; cycle();
      flush = 1'b0;
      drive(vt[i].pc, vt[i].inst, vt[i].br, vt[i].tgt, vt[i].pr, vt[i].jmp, 1'b1);
      cycle();
      chk("tv_valid", out_valid, 1'b1);
      chk("tv_count", count, 3'd1);
      chk("tv_pc", out_pc, vt[i].e_pc);
      chk("tv_inst", out_inst, vt[i].e_inst);
      chk("tv_recv", out_recv_pc, vt[i].e_recv);
      chk("tv_pred", out_pred, vt[i].e_pred);
      chk("tv_ovf", br_overflow, vt[i].e_ovf);
      in_valid = 1'b0; out_ready = 1'b1; cycle();
      out_ready = 1'b0;
    end

    // Fill to DEPTH with decode stalled, then drain in order and refill across the wrap.
    flush = 1'b1; cycle(); flush = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive_rand(1'b1); in_pc = 16'h1000 + 16'(j * 16);
      cycle();
    end
    chk("fill_ready", in_ready, 1'b0);
    chk("fill_count", count, 3'd4);
    drive_rand(1'b1); in_pc = 16'h2000;
    out_ready = 1'b1;
    cycle();
    chk("full_hold_count", count, 3'd3);
    in_valid = 1'b0;
    for (int j = 1; j < 4; j++) begin
      chk("drain_order", out_pc[63:48], 16'h1000 + 16'(j * 16));
      cycle();
    end
    chk("drained", out_valid, 1'b0);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin drive_rand(1'b1); cycle(); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Flush at count 3 with a concurrent overflowing push.
    out_ready = 1'b0;
    drive_rand(1'b1); in_br_sel = 4'b0111; cycle();
    chk("pre_flush_ovf", br_overflow, 1'b1);
    repeat (2) begin drive_rand(1'b1); cycle(); end
    chk("pre_flush_count", count, 3'd3);
    drive_rand(1'b1); in_br_sel = 4'b1111; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", count, 3'd0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_ovf", br_overflow, 1'b0);
    out_ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("flush_dropped", out_valid, 1'b0);
    end

    // Asynchronous reset in the middle of a cycle.
    out_ready = 1'b0;
    repeat (2) begin drive_rand(1'b1); cycle(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_ready", in_ready, 1'b1);
    mq.delete();
    movf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive_rand(($urandom % 4) != 0);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
